// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory controller.
// Opcodes, state encoding, beat counter type and small state/layout helpers.
package idli_pkg;

  localparam logic [7:0] SQI_OP_READ  = 8'h03;
  localparam logic [7:0] SQI_OP_WRITE = 8'h02;

  localparam int SQI_CMD_BEATS  = 2;
  localparam int SQI_ADDR_BEATS = 6;
  localparam int SQI_DATA_BEATS = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_GAP
  } idli_sqi_state_t;

  typedef logic [2:0] idli_beat_t;

  // States in which the chips are selected and sck toggles.
  function automatic logic idli_busy(input idli_sqi_state_t s);
    return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DUMMY) ||
           (s == ST_RDATA) || (s == ST_WDATA);
  endfunction

  function automatic logic idli_drives(input idli_sqi_state_t s);
    return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_WDATA);
  endfunction

  // Split-lane layout: high byte feeds chip1 lane, low byte feeds chip0 lane.
  function automatic logic [31:0] idli_wdata_layout(input logic [15:0] w);
    return {w[15:8], 8'h00, w[7:0], 8'h00};
  endfunction

endpackage

// File: rtl/idli_sqi_shift_m.sv
// 32-bit nibble shift register: chained mode serialises cmd/addr nibbles,
// split mode runs two 16-bit lanes (chip1 high, chip0 low) for data beats.
module idli_sqi_shift_m (
  input  logic        i_clk,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_shift,
  input  logic        i_split,
  input  logic [7:0]  i_nib,
  output logic [7:0]  o_tx,
  output logic [7:0]  o_rx
);

  logic [31:0] r_q;
  logic [3:0]  w_in_hi;
  logic [3:0]  w_in_lo;

  always_comb begin
    w_in_hi = i_split ? i_nib[7:4] : r_q[15:12];
    w_in_lo = i_split ? i_nib[3:0] : 4'h0;
  end

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {r_q[27:16], w_in_hi, r_q[11:0], w_in_lo};
    end
  end

  assign o_tx = {r_q[31:28], r_q[15:12]};
  assign o_rx = {r_q[19:16], r_q[3:0]};

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// Core-side SQI controller: 16-bit word reads/writes over two 4-bit SQI SRAMs
// in lockstep (chip1 on sio[7:4] = high byte, chip0 on sio[3:0] = low byte).
module idli_sqi_ctrl_m
  import idli_pkg::*;
#(
  parameter int DUMMY_BEATS  = 2,
  parameter int CS_GAP_BEATS = 1
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_sqi_req_vld,
  output logic        o_sqi_req_rdy,
  input  logic        i_sqi_req_wr,
  input  logic [15:0] i_sqi_req_addr,
  input  logic [15:0] i_sqi_req_data,
  output logic        o_sqi_rsp_vld,
  output logic [15:0] o_sqi_rsp_data,
  output logic        o_sqi_sck,
  output logic        o_sqi_cs,
  output logic        o_sqi_sio_oe,
  output logic [7:0]  o_sqi_sio,
  input  logic [7:0]  i_sqi_sio
);

  localparam idli_beat_t LAST_CMD   = idli_beat_t'(SQI_CMD_BEATS - 1);
  localparam idli_beat_t LAST_ADDR  = idli_beat_t'(SQI_ADDR_BEATS - 1);
  localparam idli_beat_t LAST_DUMMY = idli_beat_t'(DUMMY_BEATS - 1);
  localparam idli_beat_t LAST_DATA  = idli_beat_t'(SQI_DATA_BEATS - 1);
  localparam idli_beat_t LAST_GAP   = idli_beat_t'(CS_GAP_BEATS - 1);

  idli_sqi_state_t r_state;
  idli_sqi_state_t w_nxt_state;
  logic            r_phase;
  logic            w_nxt_phase;
  idli_beat_t      r_beat;
  idli_beat_t      w_nxt_beat;
  logic            r_wr;
  logic [15:0]     r_wdata;
  logic            r_sck;
  logic            r_cs;
  logic            r_oe;
  logic            r_rsp_vld;
  logic [15:0]     r_rsp_data;

  logic            w_last;
  logic            w_accept;
  logic            w_done;
  logic            w_load;
  logic [31:0]     w_load_val;
  logic            w_shift;
  logic            w_split;
  logic [7:0]      w_tx;
  logic [7:0]      w_rx;
  logic [15:0]     w_rdata;
  logic [7:0]      w_sio;

  idli_sqi_shift_m u_shift (
    .i_clk      (i_sqi_gck),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_shift    (w_shift),
    .i_split    (w_split),
    .i_nib      (i_sqi_sio),
    .o_tx       (w_tx),
    .o_rx       (w_rx)
  );

  // Final read word: previous beat's nibbles plus the ones on the bus now.
  assign w_rdata = {w_rx[7:4], i_sqi_sio[7:4], w_rx[3:0], i_sqi_sio[3:0]};

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_beat  = r_beat;
    w_last      = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_shift     = 1'b0;
    w_split     = 1'b0;

    case (r_state)
      ST_CMD:   w_last = (r_beat == LAST_CMD);
      ST_ADDR:  w_last = (r_beat == LAST_ADDR);
      ST_DUMMY: w_last = (r_beat == LAST_DUMMY);
      ST_RDATA: w_last = (r_beat == LAST_DATA);
      ST_WDATA: w_last = (r_beat == LAST_DATA);
      ST_GAP:   w_last = (r_beat == LAST_GAP);
      default:  w_last = 1'b0;
    endcase

    if (r_state == ST_IDLE) begin
      w_nxt_phase = 1'b0;
      w_nxt_beat  = '0;
      if (i_sqi_req_vld) begin
        w_accept    = 1'b1;
        w_nxt_state = ST_CMD;
        w_load      = 1'b1;
        w_load_val  = {(i_sqi_req_wr ? SQI_OP_WRITE : SQI_OP_READ), 8'h00, i_sqi_req_addr};
      end
    end else if (!r_phase) begin
      w_nxt_phase = 1'b1;
    end else begin
      // End of a beat's high phase: sample/shift, then advance beat or state.
      w_nxt_phase = 1'b0;
      w_nxt_beat  = r_beat + 3'd1;
      w_shift     = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                    (r_state == ST_RDATA) || (r_state == ST_WDATA);
      w_split     = (r_state == ST_RDATA) || (r_state == ST_WDATA);
      if (w_last) begin
        w_nxt_beat = '0;
        case (r_state)
          ST_CMD: w_nxt_state = ST_ADDR;
          ST_ADDR: begin
            if (r_wr) begin
              w_nxt_state = ST_WDATA;
              w_load      = 1'b1;
              w_load_val  = idli_wdata_layout(r_wdata);
            end else begin
              w_nxt_state = (DUMMY_BEATS == 0) ? ST_RDATA : ST_DUMMY;
            end
          end
          ST_DUMMY: w_nxt_state = ST_RDATA;
          ST_RDATA, ST_WDATA: begin
            w_nxt_state = ST_GAP;
            w_done      = 1'b1;
          end
          default: w_nxt_state = ST_IDLE;
        endcase
      end
    end
  end

  // Pin-facing registers are computed from the next state so cs/sck/oe are glitch-free.
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      r_state    <= ST_IDLE;
      r_phase    <= 1'b0;
      r_beat     <= '0;
      r_wr       <= 1'b0;
      r_sck      <= 1'b0;
      r_cs       <= 1'b1;
      r_oe       <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_phase   <= w_nxt_phase;
      r_beat    <= w_nxt_beat;
      r_sck     <= idli_busy(w_nxt_state) & w_nxt_phase;
      r_cs      <= ~idli_busy(w_nxt_state);
      r_oe      <= idli_drives(w_nxt_state);
      r_rsp_vld <= w_done;
      if (w_accept) begin
        r_wr <= i_sqi_req_wr;
      end
      if (w_done && !r_wr) begin
        r_rsp_data <= w_rdata;
      end
    end
  end

  always_ff @(posedge i_sqi_gck) begin
    if (w_accept) begin
      r_wdata <= i_sqi_req_data;
    end
  end

  // Cmd/addr nibbles broadcast to both chips; data beats use the split lanes.
  always_comb begin
    w_sio = 8'h00;
    if (r_oe) begin
      w_sio = (r_state == ST_WDATA) ? w_tx : {w_tx[7:4], w_tx[7:4]};
    end
  end

  assign o_sqi_req_rdy  = (r_state == ST_IDLE);
  assign o_sqi_rsp_vld  = r_rsp_vld;
  assign o_sqi_rsp_data = r_rsp_data;
  assign o_sqi_sck      = r_sck;
  assign o_sqi_cs       = r_cs;
  assign o_sqi_sio_oe   = r_oe;
  assign o_sqi_sio      = w_sio;

endmodule
